// File: rtl/laser_drop_fifo_if.sv
// Bus bundle for laser_drop_fifo: multi-lane write side,
// single-entry pop side, occupancy and status flags.
interface laser_drop_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int LANES = 2
);
  localparam int CW = $clog2(LANES) + 1;
  localparam int SW = $clog2(DEPTH) + 1;

  logic                   clear;
  logic [LANES*WIDTH-1:0] D;
  logic                   load;
  logic [CW-1:0]          load_count;
  logic                   read;
  logic [WIDTH-1:0]       Q;
  logic [SW-1:0]          size;
  logic                   empty;
  logic                   full;
  logic                   almost_empty;
  logic                   almost_full;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output clear, D, load, load_count, read,
    input  Q, size, empty, full,
    input  almost_empty, almost_full,
    input  overflow, underflow
  );

  modport slave (
    input  clear, D, load, load_count, read,
    output Q, size, empty, full,
    output almost_empty, almost_full,
    output overflow, underflow
  );
endinterface

// File: rtl/laser_drop_fifo.sv
// Multi-lane write, single pop FWFT FIFO with all-or-nothing
// writes and sticky overflow/underflow flags.
module laser_drop_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int LANES    = 2,
  parameter int AF_LEVEL = DEPTH - LANES,
  parameter int AE_LEVEL = 1
) (
  input logic             clock,
  input logic             reset_n,
  laser_drop_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam int SX = SW + 1;
  localparam int CW = $clog2(LANES) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [SW-1:0]    r_size;
  logic             r_ovf;
  logic             r_unf;

  logic             w_pop;
  logic             w_cnt_ok;
  logic [SX-1:0]    w_space;
  logic             w_wr;
  logic             w_wr_en;
  logic [SW-1:0]    w_add;
  logic [SW-1:0]    w_size_nxt;

  // Free room counts the slot freed by a same-cycle pop.
  assign w_pop    = bus.read && (r_size != '0);
  assign w_cnt_ok = (bus.load_count != '0) &&
                    (bus.load_count <= CW'(LANES));
  assign w_space  = SX'(DEPTH) - {1'b0, r_size} +
                    SX'(w_pop);
  assign w_wr     = bus.load && w_cnt_ok &&
                    (w_space >= SX'(bus.load_count));
  assign w_wr_en  = w_wr && !bus.clear;
  assign w_add    = w_wr ? SW'(bus.load_count) : '0;
  assign w_size_nxt = r_size + w_add - SW'(w_pop);

  // Pointers, occupancy and sticky errors; clear beats load/read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_size   <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (bus.clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_size   <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + AW'(bus.load_count);
      r_size <= w_size_nxt;
      if (bus.load && !w_wr)
        r_ovf <= 1'b1;
      if (bus.read && (r_size == '0))
        r_unf <= 1'b1;
    end
  end

  // Lane storage; contents survive reset and clear by design.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_wr_en && (CW'(i) < bus.load_count))
        r_mem[r_wr_ptr + AW'(i)] <=
          bus.D[i*WIDTH +: WIDTH];
    end
  end

  assign bus.Q            = r_mem[r_rd_ptr];
  assign bus.size         = r_size;
  assign bus.empty        = (r_size == '0);
  assign bus.full         = (r_size == SW'(DEPTH));
  assign bus.almost_empty = (r_size <= SW'(AE_LEVEL));
  assign bus.almost_full  = (r_size >= SW'(AF_LEVEL));
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_laser_drop_fifo.sv
// Directed and model-checked bench for laser_drop_fifo
// (WIDTH=8, DEPTH=64, LANES=2).
module tb_laser_drop_fifo;
  localparam int W  = 8;
  localparam int DP = 64;
  localparam int LN = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  laser_drop_fifo_if #(.WIDTH(W), .DEPTH(DP), .LANES(LN)) bus();

  laser_drop_fifo #(.WIDTH(W), .DEPTH(DP), .LANES(LN)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int ld; int cnt; int d; int rd; int clr;
    int esz; int qv; int eq; int eovf; int eunf;
    int eemp; int efull; int eae; int eaf;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic [1:0] cnt,
                      input logic [15:0] d, input logic rd,
                      input logic clr);
    int sz;
    int sp;
    bit pop;
    bit wr;
    @(negedge clk);
    bus.load = ld;
    bus.load_count = cnt;
    bus.D = d;
    bus.read = rd;
    bus.clear = clr;
    sz = mq.size();
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop = rd && (sz > 0);
      sp  = DP - sz + (pop ? 1 : 0);
      wr  = ld && (cnt >= 1) && (int'(cnt) <= LN) &&
            (sp >= int'(cnt));
      if (ld && !wr) m_ovf = 1'b1;
      if (rd && sz == 0) m_unf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (wr)
        for (int i = 0; i < int'(cnt); i++)
          mq.push_back(d[i*8 +: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int pairs);
    for (int k = 0; k < pairs; k++)
      step(1'b1, 2'd2, {8'(2*k+1), 8'(2*k)}, 1'b0, 1'b0);
  endtask

  task automatic chk_model();
    int sz;
    sz = mq.size();
    chk("m_size", 32'(bus.size), sz);
    chk("m_empty", 32'(bus.empty), (sz == 0) ? 1 : 0);
    chk("m_full", 32'(bus.full), (sz == DP) ? 1 : 0);
    chk("m_ae", 32'(bus.almost_empty), (sz <= 1) ? 1 : 0);
    chk("m_af", 32'(bus.almost_full), (sz >= 62) ? 1 : 0);
    chk("m_ovf", 32'(bus.overflow), 32'(m_ovf));
    chk("m_unf", 32'(bus.underflow), 32'(m_unf));
    if (sz > 0) chk("m_q", 32'(bus.Q), 32'(mq[0]));
  endtask

  vec_t tv[12];

  initial begin
    tv[0]  = '{1,2,'hBBAA,0,0, 2,1,'hAA,0,0,0,0,0,0};
    tv[1]  = '{0,0,0,1,0,      1,1,'hBB,0,0,0,0,1,0};
    tv[2]  = '{0,0,0,1,0,      0,0,0,0,0,1,0,1,0};
    tv[3]  = '{0,0,0,1,0,      0,0,0,0,1,1,0,1,0};
    tv[4]  = '{0,0,0,0,1,      0,0,0,0,0,1,0,1,0};
    tv[5]  = '{1,0,'h1234,0,0, 0,0,0,1,0,1,0,1,0};
    tv[6]  = '{1,3,'h1234,0,0, 0,0,0,1,0,1,0,1,0};
    tv[7]  = '{1,2,'h2211,1,1, 0,0,0,0,0,1,0,1,0};
    tv[8]  = '{1,1,'h00CC,0,0, 1,1,'hCC,0,0,0,0,1,0};
    tv[9]  = '{1,2,'hEEDD,1,0, 2,1,'hDD,0,0,0,0,0,0};
    tv[10] = '{1,1,'h00FF,0,0, 3,1,'hDD,0,0,0,0,0,0};
    tv[11] = '{0,0,0,1,0,      2,1,'hEE,0,0,0,0,0,0};

    bus.load = 1'b0;
    bus.load_count = '0;
    bus.D = '0;
    bus.read = 1'b0;
    bus.clear = 1'b0;

    #12;
    chk("rst_size", 32'(bus.size), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ae", 32'(bus.almost_empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_af", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(1'(tv[i].ld), 2'(tv[i].cnt), 16'(tv[i].d),
           1'(tv[i].rd), 1'(tv[i].clr));
      chk($sformatf("v%0d_size", i), 32'(bus.size), tv[i].esz);
      if (tv[i].qv != 0)
        chk($sformatf("v%0d_q", i), 32'(bus.Q), tv[i].eq);
      chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), tv[i].eovf);
      chk($sformatf("v%0d_unf", i), 32'(bus.underflow), tv[i].eunf);
      chk($sformatf("v%0d_emp", i), 32'(bus.empty), tv[i].eemp);
      chk($sformatf("v%0d_full", i), 32'(bus.full), tv[i].efull);
      chk($sformatf("v%0d_ae", i), 32'(bus.almost_empty), tv[i].eae);
      chk($sformatf("v%0d_af", i), 32'(bus.almost_full), tv[i].eaf);
    end

    // fill to 64, overflow on one more, contents intact
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    fill(32);
    chk("f_size", 32'(bus.size), 64);
    chk("f_full", 32'(bus.full), 1);
    chk("f_af", 32'(bus.almost_full), 1);
    chk("f_ovf0", 32'(bus.overflow), 0);
    step(1'b1, 2'd1, 16'h00AB, 1'b0, 1'b0);
    chk("f_size2", 32'(bus.size), 64);
    chk("f_full2", 32'(bus.full), 1);
    chk("f_ovf1", 32'(bus.overflow), 1);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("drain_q%0d", i), 32'(bus.Q), i);
      step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_unf", 32'(bus.underflow), 0);

    // size 63: two-lane load plus read is accepted
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    fill(31);
    chk("s62_size", 32'(bus.size), 62);
    chk("s62_af", 32'(bus.almost_full), 1);
    step(1'b1, 2'd1, 16'h003E, 1'b0, 1'b0);
    chk("s63_size", 32'(bus.size), 63);
    chk("s63_af", 32'(bus.almost_full), 1);
    chk("s63_full", 32'(bus.full), 0);
    step(1'b1, 2'd2, 16'h4140, 1'b1, 1'b0);
    chk("s63rw_size", 32'(bus.size), 64);
    chk("s63rw_ovf", 32'(bus.overflow), 0);
    chk("s63rw_full", 32'(bus.full), 1);
    chk("s63rw_q", 32'(bus.Q), 1);

    // size 63: two-lane load without read is rejected
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    fill(31);
    step(1'b1, 2'd1, 16'h003E, 1'b0, 1'b0);
    step(1'b1, 2'd2, 16'h5150, 1'b0, 1'b0);
    chk("s63w_size", 32'(bus.size), 63);
    chk("s63w_ovf", 32'(bus.overflow), 1);
    chk("s63w_q", 32'(bus.Q), 0);

    // random traffic against the queue model
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    for (int c = 0; c < 200; c++) begin
      step(1'($urandom_range(0, 1)),
           2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(1, 2)),
           16'($urandom),
           1'($urandom_range(0, 2) == 0),
           1'b0);
      chk_model();
    end

    // asynchronous reset mid-cycle with 10 entries
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    fill(5);
    chk("pre_rst_size", 32'(bus.size), 10);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_size", 32'(bus.size), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd1, 16'h0077, 1'b0, 1'b0);
    chk("post_rst_q", 32'(bus.Q), 32'h77);
    chk("post_rst_size", 32'(bus.size), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/laser_drop_fifo.md
LASER_DROP_FIFO -- requirements
Module: laser_drop_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bits per FIFO entry.
REQ-002 The block SHALL have parameter DEPTH, default 64: entry count; power of two, >= 4.
REQ-003 The block SHALL have parameter LANES, default 2: max entries written per cycle; 1 <= LANES <= DEPTH/2.
REQ-004 The block SHALL have parameter AF_LEVEL, default DEPTH-LANES: almost_full threshold.
REQ-005 The block SHALL have parameter AE_LEVEL, default 1: almost_empty threshold.
REQ-006 The block SHALL have clock  input  1  rising-edge clock; the single clock domain.
REQ-007 The block SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have clear  input  1  synchronous flush.
REQ-009 The block SHALL have D  input  LANES*WIDTH  write data; lane i = D[i*WIDTH +: WIDTH]; lane 0 is enqueued first.
REQ-010 The block SHALL have load  input  1  write request.
REQ-011 The block SHALL have load_count  input  $clog2(LANES)+1  number of valid lanes (1..LANES).
REQ-012 The block SHALL have read  input  1  pop request for one entry.
REQ-013 The block SHALL have Q  output  WIDTH  head entry (first-word-fall-through).
REQ-014 The block SHALL have size  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 The block SHALL have empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-016 The block SHALL have overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Q SHALL equal the entry at the read pointer combinationally; Q is don't-care when empty.
REQ-018 empty SHALL be (size==0); full SHALL be (size==DEPTH); almost_empty SHALL be (size<=AE_LEVEL); almost_full SHALL be (size>=AF_LEVEL). All flags SHALL be combinational from registered size.
REQ-019 A write SHALL be accepted iff load=1, 1<=load_count<=LANES and DEPTH-size_next_pop >= load_count, where size_next_pop = size minus 1 when a pop is accepted in the same cycle.
REQ-020 An accepted write SHALL store lanes 0..load_count-1 at write_ptr, write_ptr+1, ... modulo DEPTH, and SHALL advance write_ptr by load_count.
REQ-021 A write SHALL be all-or-nothing: a rejected write stores no lanes and moves no pointers.
REQ-022 A pop SHALL be accepted iff read=1 and size>0; an accepted pop SHALL advance read_ptr by 1 modulo DEPTH.
REQ-023 With a simultaneous accepted pop and accepted write, the next size SHALL be size - 1 + load_count; both SHALL occur in the same cycle.
REQ-024 A pop and a write in the same cycle SHALL use the pre-edge read_ptr and write_ptr; a write into the slot being popped (full FIFO) SHALL be legal.
REQ-025 Pointers SHALL wrap silently at DEPTH with no bubble; size SHALL never exceed DEPTH or go below 0.
REQ-026 overflow SHALL set on the edge after load=1 with the write rejected, including load_count=0 or load_count>LANES.
REQ-027 underflow SHALL set on the edge after read=1 with size==0.
REQ-028 overflow and underflow SHALL hold until clear or reset.
REQ-029 Each write and each pop SHALL take effect at the next rising edge (latency 1); Q SHALL reflect a write into an empty FIFO one cycle after the load edge.
REQ-030 clear=1 SHALL have priority over load and read: it zeroes size, pointers, overflow and underflow at the edge, and the same-cycle load and read SHALL be ignored.
REQ-031 Storage contents SHALL NOT be reset or cleared.

Reset
REQ-032 reset_n=0 SHALL asynchronously force size=0, read_ptr=0, write_ptr=0, overflow=0 and underflow=0, giving empty=1, almost_empty=1, full=0 and almost_full=0 (defaults).
REQ-033 Reset mid-operation SHALL discard all contents immediately; the first write after reset_n rises SHALL land at index 0.
REQ-034 Release of reset_n SHALL be synchronised externally; the block SHALL accept operations on the first edge after release.

Verification
REQ-035 Bench scenario: reset, then load D=16'hBBAA with load_count=2 -> next cycle size=2, Q=8'hAA; read -> Q=8'hBB, size=1.
REQ-036 Bench scenario: fill to DEPTH=64 with 32 two-lane loads, then load one more -> full=1, size=64, overflow=1, contents unchanged.
REQ-037 Bench scenario: at size=63, load count=2 plus read in the same cycle -> accepted, size=64, no overflow; at size=63 with load count=2 and no read -> rejected, overflow=1.
REQ-038 Bench scenario: 200 cycles of random loads and reads against a reference model -> Q order and size match across pointer wrap; almost flags correct at 1/2 and 62/63.
REQ-039 Bench scenario: read when empty -> underflow=1, size stays 0; then clear -> underflow=0, size=0.
REQ-040 Bench scenario: assert reset_n=0 mid-cycle with size=10 -> size=0 and empty=1 before the next clock edge.
